// File: rtl/gps_uart_rx_if.sv
// gps_uart_rx_if: byte stream from the GPS UART receiver to the NMEA parser
interface gps_uart_rx_if;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       rx_busy;
  logic       frame_err;
  modport master (output uart_data, uart_valid, rx_busy, frame_err);
  modport slave  (input  uart_data, uart_valid, rx_busy, frame_err);
endinterface

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 UART receiver for a GPS NMEA stream, mid-bit sampling, back-to-back frames.
// Stop-bit checking (frame_err, drop of bad frames) is enabled by GPS_RX_FRAME_CHECK_EN.
module gps_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_Rx_Serial,
  gps_uart_rx_if.master  rx
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_C = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sr, sr_n, data_q;
  logic done, stop_good, valid_q, armed;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx_Serial;
      rx_s <= rx_m;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sr      <= sr_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    sr_n    = sr;
    done    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = (!rx_s && armed) ? START : IDLE;
      end
      START: if (cnt == HALF_C) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST_C) begin
        cnt_n   = '0;
        sr_n    = {rx_s, sr[7:1]};
        bit_n   = bit_idx + 3'd1;
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == LAST_C) begin
        cnt_n   = '0;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // A low stop bit disarms start detection until the line has been seen high,
  // so a held break produces a single frame rather than a stream of 0x00s.
  always_ff @(posedge clk or posedge rst)
    if (rst) armed <= 1'b1;
    else if (rx_s) armed <= 1'b1;
    else if (done) armed <= 1'b0;
`ifdef GPS_RX_FRAME_CHECK_EN
  logic ferr_q;
  assign stop_good = rx_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) ferr_q <= 1'b0;
    else ferr_q <= done && !rx_s;
  assign rx.frame_err = ferr_q;
`else
  assign stop_good = 1'b1;
  assign rx.frame_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= done && stop_good;
      data_q  <= (done && stop_good) ? sr : data_q;
    end
  assign rx.uart_data  = data_q;
  assign rx.uart_valid = valid_q;
  assign rx.rx_busy    = (state != IDLE);
endmodule

// File: doc/gps_uart_rx.md
GPS_UART_RX -- requirements
Module: gps_uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); SHALL be >= 4.
REQ-002 Port: clk  input  1  system clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_Rx_Serial  input  1  asynchronous serial line from GPS module; idle high; 8N1 framing, LSB first.
REQ-005 Port: uart_data  output  8  last received byte; held stable between uart_valid pulses.
REQ-006 Port: uart_valid  output  1  single-cycle pulse marking a new byte on uart_data; feeds the NMEA sentence parser.
REQ-007 Port: rx_busy  output  1  high while a frame is in progress (state != IDLE).
REQ-008 Port: frame_err  output  1  single-cycle pulse when the sampled stop bit is 0.

Function
REQ-009 i_Rx_Serial SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-011 IDLE: on the first cycle rx_s==0, go to START with bit counter cleared to 0.
REQ-012 START: counter increments each cycle; at count CLKS_PER_BIT/2 (integer division), sample rx_s; if 0, go to DATA with counter 0; if 1 (glitch), return to IDLE with no output.
REQ-013 DATA: sample rx_s every CLKS_PER_BIT cycles after the previous sample; shift LSB first into an 8-bit register; after the 8th sample, go to STOP.
REQ-014 STOP: sample rx_s CLKS_PER_BIT cycles after the 8th data sample, then return to IDLE on the next cycle. Not waiting for the end of the stop bit allows back-to-back frames.
REQ-015 A good stop bit SHALL cause uart_data to be updated and uart_valid to be high for exactly one cycle, the cycle after the stop sample.
REQ-016 A bad stop bit SHALL be handled per REQ-022/REQ-023.
REQ-017 Latency: uart_valid rises 2 + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the falling edge at the i_Rx_Serial pin.
REQ-018 The line held low (break) SHALL yield one frame_err event; the block SHALL then remain in IDLE until rx_s returns high before accepting a new start.
REQ-019 Counters SHALL be sized $clog2(CLKS_PER_BIT)+1 bits; no wrap SHALL occur within a state.

Reset
REQ-020 While rst is high: state=IDLE, counters=0, synchronizer flops=1, uart_data=8'h00, uart_valid=0, rx_busy=0, frame_err=0.
REQ-021 Asserting rst mid-frame SHALL abort the frame with no uart_valid; after release, the next falling edge starts a fresh frame.

Configuration
REQ-022 With macro GPS_RX_FRAME_CHECK_EN defined: a bad stop bit SHALL pulse frame_err for one cycle, SHALL NOT assert uart_valid, and SHALL leave uart_data unchanged.
REQ-023 Without GPS_RX_FRAME_CHECK_EN: frame_err SHALL be tied 0, and every frame SHALL deliver uart_data with uart_valid regardless of the stop bit value.

Verification (CLKS_PER_BIT=16 unless noted)
REQ-024 Drive 8N1 frame 0x24 ('$') after reset -> one uart_valid pulse, uart_data=8'h24, rx_busy low within 2 cycles after the pulse.
REQ-025 Drive back-to-back "$GPGGA," (0x24,0x47,0x50,0x47,0x47,0x41,0x2C) with no idle gap -> 7 uart_valid pulses in order with matching bytes; no frame_err.
REQ-026 Drive a 5-cycle low glitch on idle line -> no uart_valid, rx_busy returns low by cycle CLKS_PER_BIT/2+4.
REQ-027 Drive 0x4E with stop bit 0, macro defined -> frame_err pulses once, no uart_valid, uart_data keeps previous value; macro undefined -> uart_valid with uart_data=8'h4E.
REQ-028 Assert rst during data bit 4 of 0x31, then send 0x32 -> only one uart_valid, with uart_data=8'h32.
REQ-029 CLKS_PER_BIT=868, send 0x45 -> uart_valid at latency per REQ-017, uart_data=8'h45.
